// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared types and constants for the data-memory responder.
//
// Contents:
//   DMEM_ADDR_W   default word-address width (512-word RAM)
//   dmem_state_e  responder FSM state encoding
//   dmem_err_e    error class recorded when a request is captured
//   classify()    maps a raw request onto its error class
package dmem_pkg;

  localparam int DMEM_ADDR_W = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } dmem_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_BOTH     = 2'b01,
    ERR_MISALIGN = 2'b10,
    ERR_RANGE    = 2'b11
  } dmem_err_e;

  // Only one class is recorded. Conflicting read+write wins over misalignment,
  // which wins over an address beyond the RAM.
  function automatic dmem_err_e classify(input logic rd, input logic wr,
                                         input logic [31:0] addr, input int addrW);
    dmem_err_e cls;
    cls = ERR_NONE;
    if (rd && wr)
      cls = ERR_BOTH;
    else if (addr[1:0] != 2'b00)
      cls = ERR_MISALIGN;
    else if ((addr >> (addrW + 2)) != 32'd0)
      cls = ERR_RANGE;
    return cls;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if -- load/store bus between the core and the data-memory responder.
//
// Signals:
//   MemRead, MemWrite   request strobes, held by the core until dReady
//   dAddress            byte address
//   dWriteData          store data
//   dReadData           load data (registered in the responder)
//   dReady              one-cycle completion pulse
//   dError              error flag, meaningful only while dReady is high
//   busy                responder is working on a request
// Modports: master (core side), slave (responder side).
interface dmem_if;

  logic        MemRead;
  logic        MemWrite;
  logic [31:0] dAddress;
  logic [31:0] dWriteData;
  logic [31:0] dReadData;
  logic        dReady;
  logic        dError;
  logic        busy;

  modport master (
    output MemRead, MemWrite, dAddress, dWriteData,
    input  dReadData, dReady, dError, busy
  );

  modport slave (
    input  MemRead, MemWrite, dAddress, dWriteData,
    output dReadData, dReady, dError, busy
  );

endinterface

// File: rtl/dmem_ram.sv
// dmem_ram -- single-port synchronous word RAM, 2^ADDR_W x 32, no reset.
//
// Ports:
//   clk   clock, rising edge
//   we    write enable
//   addr  word address
//   din   write data
//   dout  read data, valid one cycle after addr is presented (read-first)
module dmem_ram #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout
);

  logic [31:0] r_mem [2**ADDR_W];

  // Contents survive reset on purpose; the core expects memory to persist.
  always_ff @(posedge clk) begin
    if (we)
      r_mem[addr] <= din;
    dout <= r_mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder -- answers core load/store requests from a 2^ADDR_W-word RAM
// after WAIT_CYCLES wait states, returning a one-cycle dReady pulse and dError
// for conflicting, misaligned or out-of-range requests.
//
// Ports:
//   clk    clock, rising edge
//   rst    synchronous active-high reset
//   bus    dmem_if.slave (MemRead, MemWrite, dAddress, dWriteData in;
//          dReadData, dReady, dError, busy out)
// Optional (macro DMEM_STATS_EN):
//   rd_count   completed legal loads, wraps
//   wr_count   completed legal stores, wraps
//   err_count  error responses, saturates at 0xFFFF
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  dmem_if.slave       bus
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [15:0] err_count
`endif
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_e       r_state;
  dmem_state_e       w_nextState;
  dmem_err_e         r_errClass;
  dmem_err_e         w_errClass;
  logic [3:0]        r_waitCnt;
  logic [ADDR_W-1:0] r_wordAddr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_dReadData;
  logic              r_isWrite;
  logic              w_req;
  logic              w_capture;
  logic              w_err;
  logic              w_ramWe;
  logic [ADDR_W-1:0] w_ramAddr;
  logic [31:0]       w_ramDout;

  assign w_req      = bus.MemRead | bus.MemWrite;
  assign w_capture  = (r_state == IDLE) && w_req;
  assign w_errClass = classify(bus.MemRead, bus.MemWrite, bus.dAddress, ADDR_W);
  assign w_err      = (r_errClass != ERR_NONE);

  // While idle the RAM looks at the live bus address so that, even with zero
  // wait states, the read word is already on dout during ACCESS.
  assign w_ramAddr = (r_state == IDLE) ? bus.dAddress[ADDR_W+1:2] : r_wordAddr;
  assign w_ramWe   = (r_state == ACCESS) && r_isWrite && !w_err && !rst;

  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk  (clk),
    .we   (w_ramWe),
    .addr (w_ramAddr),
    .din  (r_wdata),
    .dout (w_ramDout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  // Next-state logic: the wait counter reaching zero ends WAIT.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (w_req) w_nextState = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
      WAIT:    if (r_waitCnt == 4'd0) w_nextState = ACCESS;
      ACCESS:  w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Request capture, wait countdown and load data. A request with both strobes
  // high is handled as a load so that its error response clears dReadData.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_waitCnt   <= 4'd0;
      r_wordAddr  <= '0;
      r_wdata     <= 32'd0;
      r_isWrite   <= 1'b0;
      r_errClass  <= ERR_NONE;
      r_dReadData <= 32'd0;
    end else begin
      if (w_capture) begin
        r_wordAddr <= bus.dAddress[ADDR_W+1:2];
        r_wdata    <= bus.dWriteData;
        r_isWrite  <= bus.MemWrite && !bus.MemRead;
        r_errClass <= w_errClass;
        r_waitCnt  <= WAIT_LOAD;
      end else if ((r_state == WAIT) && (r_waitCnt != 4'd0)) begin
        r_waitCnt <= r_waitCnt - 4'd1;
      end
      if ((r_state == ACCESS) && !r_isWrite)
        r_dReadData <= w_err ? 32'd0 : w_ramDout;
    end
  end

  assign bus.dReadData = r_dReadData;
  assign bus.dReady    = (r_state == RESP);
  assign bus.dError    = (r_state == RESP) && w_err;
  assign bus.busy      = (r_state != IDLE);

`ifdef DMEM_STATS_EN
  // Completion statistics, updated on the response cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count  <= 32'd0;
      wr_count  <= 32'd0;
      err_count <= 16'd0;
    end else if (r_state == RESP) begin
      if (w_err) begin
        if (err_count != 16'hFFFF)
          err_count <= err_count + 16'd1;
      end else if (r_isWrite) begin
        wr_count <= wr_count + 32'd1;
      end else begin
        rd_count <= rd_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder -- self-checking bench for dmem_responder.
// Instance A runs with two wait states, instance B with none. A word-level
// memory model per instance predicts load data, error flags and latency.
// With DMEM_STATS_EN defined the statistics counters of B are also checked.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rstA;
  logic rstB;

  always #5 clk = ~clk;

  dmem_if busA();
  dmem_if busB();

`ifdef DMEM_STATS_EN
  logic [31:0] aRd, aWr, bRd, bWr;
  logic [15:0] aErr, bErr;
`endif

  dmem_responder #(.ADDR_W(9), .WAIT_CYCLES(2)) dutA (
    .clk (clk),
    .rst (rstA),
    .bus (busA)
`ifdef DMEM_STATS_EN
    , .rd_count (aRd), .wr_count (aWr), .err_count (aErr)
`endif
  );

  dmem_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) dutB (
    .clk (clk),
    .rst (rstB),
    .bus (busB)
`ifdef DMEM_STATS_EN
    , .rd_count (bRd), .wr_count (bWr), .err_count (bErr)
`endif
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] memM   [2][512];
  bit          known  [2][512];
  logic [31:0] lastRd [2];
  bit          lastOk [2];
  int          cntRd = 0;
  int          cntWr = 0;
  int          cntErr = 0;
  int          wq[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int sel, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      busA.MemRead = rd; busA.MemWrite = wr; busA.dAddress = a; busA.dWriteData = d;
    end else begin
      busB.MemRead = rd; busB.MemWrite = wr; busB.dAddress = a; busB.dWriteData = d;
    end
  endtask

  task automatic getOut(input int sel, output logic rdy, output logic err,
                        output logic bsy, output logic [31:0] data);
    if (sel == 0) begin
      rdy = busA.dReady; err = busA.dError; bsy = busA.busy; data = busA.dReadData;
    end else begin
      rdy = busB.dReady; err = busB.dError; bsy = busB.busy; data = busB.dReadData;
    end
  endtask

  // One complete request. Called between a rising edge and the next one;
  // returns at the falling edge of the cycle after dReady with the request
  // dropped, so consecutive calls are back to back.
  task automatic applyStimulus(input int sel, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               input string tag);
    int          w;
    int          seen;
    int          idx;
    bit          expErr;
    bit          dataChk;
    logic [31:0] expData;
    logic        rdy, err, bsy;
    logic [31:0] rdata;
    w       = (sel == 0) ? 2 : 0;
    idx     = int'(addr[10:2]);
    expErr  = (rd && wr) || (addr[1:0] != 2'b00) || ((addr >> 11) != 32'd0);
    dataChk = 1'b1;
    expData = 32'd0;
    if (rd && wr) begin
      dataChk = 1'b0;
      lastOk[sel] = 1'b0;
    end else if (rd) begin
      if (expErr)
        expData = 32'd0;
      else if (known[sel][idx])
        expData = memM[sel][idx];
      else
        dataChk = 1'b0;
      lastRd[sel] = expData;
      lastOk[sel] = dataChk;
    end else begin
      expData = lastRd[sel];
      dataChk = lastOk[sel];
      if (!expErr) begin
        memM[sel][idx]  = data;
        known[sel][idx] = 1'b1;
      end
    end
    if (expErr) begin
      if (cntErr < 65535 && sel == 1) cntErr++;
    end else if (sel == 1) begin
      if (wr) cntWr++; else cntRd++;
    end

    setReq(sel, rd, wr, addr, data);
    @(posedge clk);
    @(negedge clk);
    getOut(sel, rdy, err, bsy, rdata);
    checkOutput({tag, "_busyAfterCapture"}, 32'(bsy), 32'd1);
    seen = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      getOut(sel, rdy, err, bsy, rdata);
      if (rdy) begin
        seen = k;
        break;
      end
    end
    checkOutput({tag, "_latency"}, 32'(seen), 32'(w + 1));
    if (seen > 0) begin
      checkOutput({tag, "_dError"}, 32'(err), 32'(expErr));
      if (dataChk)
        checkOutput({tag, "_dReadData"}, rdata, expData);
      @(posedge clk);
      #1;
      setReq(sel, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      getOut(sel, rdy, err, bsy, rdata);
      checkOutput({tag, "_readyDropped"}, 32'(rdy), 32'd0);
      checkOutput({tag, "_busyDropped"}, 32'(bsy), 32'd0);
    end else begin
      setReq(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    end
  endtask

  task automatic checkIdleZero(input int sel, input string tag);
    logic        rdy, err, bsy;
    logic [31:0] rdata;
    getOut(sel, rdy, err, bsy, rdata);
    checkOutput({tag, "_dReady"}, 32'(rdy), 32'd0);
    checkOutput({tag, "_dError"}, 32'(err), 32'd0);
    checkOutput({tag, "_busy"}, 32'(bsy), 32'd0);
    checkOutput({tag, "_dReadData"}, rdata, 32'd0);
    lastRd[sel] = 32'd0;
    lastOk[sel] = 1'b1;
  endtask

  initial begin
    int          r;
    int          idx;
    int          gotRdy;
    logic [31:0] a;
    logic [31:0] d;
    $display("[TB] dmem_responder bench starting");
    rstA = 1'b1;
    rstB = 1'b1;
    setReq(0, 1'b0, 1'b0, 32'd0, 32'd0);
    setReq(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rstA = 1'b0;
    rstB = 1'b0;
    @(negedge clk);
    checkIdleZero(0, "resetA");
    checkIdleZero(1, "resetB");
`ifdef DMEM_STATS_EN
    checkOutput("resetB_rdCount", bRd, 32'd0);
    checkOutput("resetB_wrCount", bWr, 32'd0);
    checkOutput("resetB_errCount", 32'(bErr), 32'd0);
`endif

    // Known background contents.
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0000, 32'hA5A5_0000, "init0");
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0020, 32'h2020_2020, "init20");
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0040, 32'h4040_4040, "init40");

    // Store then load.
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, "store10");
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, "load10");

    // Misaligned load reports an error and returns zero.
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0013, 32'h0, "misalign13");
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, "reload10");

    // Out-of-range store aliases word 0 if the range check is missing.
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0800, 32'hDEAD_BEEF, "range800");
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0, "load0");

    // Conflicting strobes.
    applyStimulus(0, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_0BAD, "both20");
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, "load20");

    // Reset while the store is waiting: nothing written, no dReady.
    setReq(0, 1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D);
    @(posedge clk);
    #1;
    rstA = 1'b1;
    setReq(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    rstA = 1'b0;
    @(negedge clk);
    checkIdleZero(0, "abort");
    gotRdy = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busA.dReady) gotRdy = 1;
    end
    checkOutput("abort_noReady", 32'(gotRdy), 32'd0);
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, "load40");

    // Randomized traffic on instance A.
    wq = '{0, 4, 8, 16};
    for (int n = 0; n < 40; n++) begin
      r   = int'($urandom_range(0, 9));
      idx = int'($urandom_range(0, 511));
      d   = $urandom;
      if (r <= 3) begin
        a = {21'd0, 9'(idx), 2'b00};
        wq.push_back(idx);
        applyStimulus(0, 1'b0, 1'b1, a, d, "rndStore");
      end else if (r <= 7) begin
        idx = wq[$urandom_range(0, wq.size() - 1)];
        a   = {21'd0, 9'(idx), 2'b00};
        applyStimulus(0, 1'b1, 1'b0, a, d, "rndLoad");
      end else if (r == 8) begin
        a = {21'd0, 9'(idx), 2'(1 + $urandom_range(0, 2))};
        applyStimulus(0, r[0], !r[0], a, d, "rndMisalign");
      end else begin
        a = ($urandom | 32'h0000_0800) & 32'hFFFF_FFFC;
        applyStimulus(0, 1'b0, 1'b1, a, d, "rndRange");
      end
    end

    // Zero-wait instance: back-to-back traffic.
    applyStimulus(1, 1'b0, 1'b1, 32'h0000_0100, 32'h1111_AAAA, "bStore100");
    applyStimulus(1, 1'b0, 1'b1, 32'h0000_0104, 32'h2222_BBBB, "bStore104");
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, "bLoad100");
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0104, 32'h0, "bLoad104");
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, "bLoad100b");
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0003, 32'h0, "bMisalign");
`ifdef DMEM_STATS_EN
    checkOutput("stats_rdCount", bRd, 32'(cntRd));
    checkOutput("stats_wrCount", bWr, 32'(cntWr));
    checkOutput("stats_errCount", 32'(bErr), 32'(cntErr));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
